// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: glyph patterns, drive polarity
// and the scan sequencer state type.
package seg_pkg;

    // Segments and decimal point are active-low: a 0 lights the element.
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = ~SEG_ON;

    // Bit order is {a,b,c,d,e,f,g}.
    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0000100;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b1100000;
    localparam logic [6:0] GLYPH_C     = 7'b0110001;
    localparam logic [6:0] GLYPH_D     = 7'b1000010;
    localparam logic [6:0] GLYPH_E     = 7'b0110000;
    localparam logic [6:0] GLYPH_F     = 7'b0111000;
    localparam logic [6:0] GLYPH_BLANK = {7{SEG_OFF}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_hex_dec.sv
// Nibble to 7-segment glyph decoder. Codes 10..15 decode to letters only in
// hex mode; in decimal mode they decode to blank.
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = GLYPH_BLANK;
        case (nibble)
            4'h0: pattern = GLYPH_0;
            4'h1: pattern = GLYPH_1;
            4'h2: pattern = GLYPH_2;
            4'h3: pattern = GLYPH_3;
            4'h4: pattern = GLYPH_4;
            4'h5: pattern = GLYPH_5;
            4'h6: pattern = GLYPH_6;
            4'h7: pattern = GLYPH_7;
            4'h8: pattern = GLYPH_8;
            4'h9: pattern = GLYPH_9;
            4'hA: pattern = hex_mode ? GLYPH_A : GLYPH_BLANK;
            4'hB: pattern = hex_mode ? GLYPH_B : GLYPH_BLANK;
            4'hC: pattern = hex_mode ? GLYPH_C : GLYPH_BLANK;
            4'hD: pattern = hex_mode ? GLYPH_D : GLYPH_BLANK;
            4'hE: pattern = hex_mode ? GLYPH_E : GLYPH_BLANK;
            4'hF: pattern = hex_mode ? GLYPH_F : GLYPH_BLANK;
            default: pattern = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: prescaled digit slots with an anode guard
// window, shadowed display data, hex/decimal glyphs and leading-zero blanking.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | just out of reset; next edge opens slot 0 with prescaler = 0
// ST_SCAN | prescaler running, scan index advances on every tick
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  slot_start
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    scan_state_t           st_q, st_nxt;
    logic [PW-1:0]         pre_q, pre_nxt;
    logic [IW-1:0]         idx_q, idx_nxt;

    logic [4*N_DIGITS-1:0] sh_val_q, sh_val_nxt;
    logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_nxt;
    logic                  sh_hex_q, sh_hex_nxt;
    logic                  sh_lz_q, sh_lz_nxt;

    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  lz_sel;
    logic [N_DIGITS-1:0]   lz_vec;
    logic                  zero_run;
    logic                  in_guard;
    logic [6:0]            glyph;

    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [N_DIGITS-1:0]   an_nxt;
    logic                  slot_nxt;

    // Sequencer: prescaler and scan index.
    always_comb begin
        st_nxt  = st_q;
        pre_nxt = '0;
        idx_nxt = idx_q;
        case (st_q)
            ST_IDLE: begin
                st_nxt  = ST_SCAN;
                pre_nxt = '0;
            end
            ST_SCAN: begin
                if (pre_q == PRE_MAX) begin
                    pre_nxt = '0;
                    idx_nxt = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                end else begin
                    pre_nxt = pre_q + 1'b1;
                end
            end
            default: begin
                st_nxt  = ST_IDLE;
                pre_nxt = '0;
                idx_nxt = '0;
            end
        endcase
    end

    always_comb begin
        sh_val_nxt = load ? value    : sh_val_q;
        sh_dp_nxt  = load ? dp_in    : sh_dp_q;
        sh_hex_nxt = load ? hex_mode : sh_hex_q;
        sh_lz_nxt  = load ? lz_blank : sh_lz_q;
    end

    // Output decode works on next-state values so the registered outputs line
    // up with the prescaler/index they belong to, and a load shows up one
    // cycle after its edge even when that edge is also a tick.
    always_comb begin
        zero_run = 1'b1;
        lz_vec   = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (sh_val_nxt[i*4 +: 4] == 4'h0);
            if (i > 0) lz_vec[i] = zero_run;
        end
    end

    always_comb begin
        nib_sel = 4'h0;
        dp_sel  = 1'b0;
        lz_sel  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                nib_sel = sh_val_nxt[i*4 +: 4];
                dp_sel  = sh_dp_nxt[i];
                lz_sel  = lz_vec[i];
            end
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            localparam logic [PW:0] GUARD_LIM = (PW + 1)'(GUARD);
            assign in_guard = ({1'b0, pre_nxt} < GUARD_LIM);
        end
    endgenerate

    seg_hex_dec u_hex_dec (
        .nibble   (nib_sel),
        .hex_mode (sh_hex_nxt),
        .pattern  (glyph)
    );

    always_comb begin
        seg_nxt  = GLYPH_BLANK;
        dp_nxt   = SEG_OFF;
        an_nxt   = '1;
        slot_nxt = (st_nxt == ST_SCAN) && (pre_nxt == '0);
        if (!in_guard) begin
            seg_nxt = (sh_lz_nxt && lz_sel) ? GLYPH_BLANK : glyph;
            dp_nxt  = dp_sel ? SEG_ON : SEG_OFF;
            for (int i = 0; i < N_DIGITS; i++) begin
                an_nxt[i] = (idx_nxt == IW'(i)) ? SEG_ON : SEG_OFF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            pre_q      <= '0;
            idx_q      <= '0;
            sh_val_q   <= '0;
            sh_dp_q    <= '0;
            sh_hex_q   <= 1'b0;
            sh_lz_q    <= 1'b0;
            seg        <= GLYPH_BLANK;
            dp         <= SEG_OFF;
            an         <= '1;
            slot_start <= 1'b0;
        end else begin
            st_q       <= st_nxt;
            pre_q      <= pre_nxt;
            idx_q      <= idx_nxt;
            sh_val_q   <= sh_val_nxt;
            sh_dp_q    <= sh_dp_nxt;
            sh_hex_q   <= sh_hex_nxt;
            sh_lz_q    <= sh_lz_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            an         <= an_nxt;
            slot_start <= slot_nxt;
        end
    end

endmodule
